seq_divider: RTL and testbench

Sequential two's-complement integer divider, the inverse operation of the combinational `multiplier` in the `twocomplement` arithmetic library. Takes an N-bit signed dividend and divisor and produces an N-bit signed quotient and remainder after a fixed latency. It uses one restoring-division step per clock, with a start/done handshake. It is intended for datapaths where a combinational N-bit divider is too slow or too large.

---
 rtl/twocomp_pkg.sv | 20 ++
 rtl/div_step.sv | 25 ++
 rtl/seq_divider.sv | 152 +++++++++++++++
 tb/tb_seq_divider.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/twocomp_pkg.sv
// Shared definitions for the two's-complement arithmetic blocks:
// divider FSM state encoding and a counter-width helper.
package twocomp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t ITER = 2'd1;
  localparam state_t FIX  = 2'd2;

  // Smallest width able to hold the value v-1 (call with N+1 to count 0..N).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference or restore.
module div_step #(
  parameter int N = 4
) (
  input  logic [N:0]   i_prem,
  input  logic         i_dbit,
  input  logic [N-1:0] i_bmag,
  output logic [N:0]   o_prem,
  output logic         o_qbit
);

  logic [N+1:0] w_shift;
  logic [N+1:0] w_diff;
  logic         w_ge;

  assign w_shift = {i_prem, i_dbit};
  assign w_diff  = w_shift - {2'b00, i_bmag};
  assign w_ge    = (w_shift >= {2'b00, i_bmag});

  // Restoring remainders stay below the divisor, so the top bit is always 0.
  assign o_qbit  = w_ge;
  assign o_prem  = w_ge ? (N+1)'(w_diff) : (N+1)'(w_shift);

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider: magnitudes are divided one restoring step per
// clock, then signs are applied and the results registered in FIX.
module seq_divider
  import twocomp_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         div_zero,
  output logic         ovf
);

  localparam int CW = clog2(N + 1);

  state_t         r_state;
  state_t         w_state_nxt;

  logic [N-1:0]   r_dvd;       // dividend magnitude, becomes quotient magnitude
  logic [N-1:0]   r_dsr;
  logic [N:0]     r_prem;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_a_in;
  logic           r_sign_q;
  logic           r_sign_r;
  logic           r_dz;
  logic           r_ov;

  logic           r_done;
  logic [N-1:0]   r_q;
  logic [N-1:0]   r_r;
  logic           r_div_zero;
  logic           r_ovf;

  logic           w_load;
  logic           w_step;
  logic           w_fix;
  logic [N-1:0]   w_amag;
  logic [N-1:0]   w_bmag;
  logic [N:0]     w_prem_nxt;
  logic           w_qbit;
  logic [N-1:0]   w_rmag;
  logic [N-1:0]   w_q_fix;
  logic [N-1:0]   w_r_fix;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = ITER;
      ITER:    if (r_cnt == CW'(1)) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    busy   = 1'b0;
    case (r_state)
      IDLE:    w_load = start;
      ITER:    begin w_step = 1'b1; busy = 1'b1; end
      FIX:     begin w_fix  = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

  assign w_amag = A[N-1] ? -A : A;
  assign w_bmag = B[N-1] ? -B : B;

  div_step #(.N(N)) u_step (
    .i_prem (r_prem),
    .i_dbit (r_dvd[N-1]),
    .i_bmag (r_dsr),
    .o_prem (w_prem_nxt),
    .o_qbit (w_qbit)
  );

  assign w_rmag  = N'(r_prem);
  assign w_q_fix = r_dz ? '1    : (r_sign_q ? -r_dvd : r_dvd);
  assign w_r_fix = r_dz ? r_a_in : (r_sign_r ? -w_rmag : w_rmag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_prem   <= '0;
      r_cnt    <= '0;
      r_a_in   <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dz     <= 1'b0;
      r_ov     <= 1'b0;
    end else if (w_load) begin
      r_dvd    <= w_amag;
      r_dsr    <= w_bmag;
      r_prem   <= '0;
      r_cnt    <= CW'(N);
      r_a_in   <= A;
      r_sign_q <= A[N-1] ^ B[N-1];
      r_sign_r <= A[N-1];
      r_dz     <= (B == '0);
      r_ov     <= (A == {1'b1, {(N-1){1'b0}}}) && (B == '1);
    end else if (w_step) begin
      r_dvd    <= {r_dvd[N-2:0], w_qbit};
      r_prem   <= w_prem_nxt;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

  // Results hold until the next FIX; the most negative / -1 case wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done     <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
      r_div_zero <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_fix) begin
        r_q        <= w_q_fix;
        r_r        <= w_r_fix;
        r_div_zero <= r_dz;
        r_ovf      <= r_ov;
      end
    end
  end

  assign done     = r_done;
  assign Q        = r_q;
  assign R        = r_r;
  assign div_zero = r_div_zero;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider at N=4.
module tb_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [3:0] Q;
  logic [3:0] R;
  logic       div_zero;
  logic       ovf;

  int n_pass  = 0;
  int n_total = 0;

  seq_divider #(.N(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .Q        (Q),
    .R        (R),
    .div_zero (div_zero),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ov;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Present operands on the falling edge; return just after the accepting edge.
  task automatic accept(input logic [3:0] a, input logic [3:0] b, input bit hold);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Cycles from the accepting edge to done, and whether busy tracked it.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = busy;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (!done && !busy) busy_ok = 1'b0;
      if (done && busy)   busy_ok = 1'b0;
    end
  endtask

  function automatic logic [9:0] ref_div(input logic [3:0] a, input logic [3:0] b);
    int ai, bi, qi, ri;
    logic dz, ov;
    ai = $signed(a);
    bi = $signed(b);
    dz = (bi == 0);
    ov = (ai == -8) && (bi == -1);
    if (dz) begin
      qi = -1; ri = ai;
    end else if (ov) begin
      qi = -8; ri = 0;
    end else begin
      qi = ai / bi; ri = ai % bi;
    end
    return {qi[3:0], ri[3:0], dz, ov};
  endfunction

  initial begin
    int lat;
    bit bok;
    logic [9:0] exp_v;

    tbl[0] = '{4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 1'b0};
    tbl[1] = '{4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 1'b0};
    tbl[2] = '{4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b0};
    tbl[3] = '{4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1};
    tbl[4] = '{4'b1000, 4'b0001, 4'b1000, 4'b0000, 1'b0, 1'b0};
    tbl[5] = '{4'b0101, 4'b0000, 4'b1111, 4'b0101, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    #12;
    check("reset_outputs", {busy, done, Q, R, div_zero, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      accept(tbl[i].a, tbl[i].b, 1'b0);
      wait_done(lat, bok);
      check($sformatf("vec%0d_latency", i), lat, 5);
      check($sformatf("vec%0d_busy", i), {31'd0, bok}, 32'd1);
      check($sformatf("vec%0d_result", i), {Q, R, div_zero, ovf},
            {tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov});
    end

    // Results hold after done while idle.
    repeat (3) @(posedge clk);
    #1;
    check("hold_after_done", {done, Q, R, div_zero}, {1'b0, 4'b1111, 4'b0101, 1'b1});

    // New start two cycles after an accept is dropped, not queued.
    accept(4'b0111, 4'b1110, 1'b0);
    @(negedge clk);
    @(negedge clk);
    A = 4'b0001; B = 4'b0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("ignored_start_result", {done, Q, R, div_zero, ovf}, {1'b1, 4'b1101, 4'b0001, 2'b00});
    @(posedge clk); #1;
    check("ignored_start_not_queued", {31'd0, busy}, 32'd0);

    // start held through done: second op accepted on the edge after done.
    accept(4'b0111, 4'b0010, 1'b1);
    A = 4'b0101; B = 4'b0000;
    wait_done(lat, bok);
    check("b2b_first_latency", lat, 5);
    check("b2b_first_result", {Q, R}, {4'b0011, 4'b0001});
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_second_accepted", {30'd0, busy, done}, 32'd2);
    wait_done(lat, bok);
    check("b2b_second_latency", lat, 5);
    check("b2b_second_result", {Q, R, div_zero, ovf}, {4'b1111, 4'b0101, 2'b10});

    // Asynchronous reset in the middle of ITER.
    accept(4'b0111, 4'b0010, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_iter", {busy, done, Q, R, div_zero, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    accept(4'b0110, 4'b0011, 1'b0);
    wait_done(lat, bok);
    check("after_reset_latency", lat, 5);
    check("after_reset_result", {Q, R, div_zero, ovf}, {4'b0010, 4'b0000, 2'b00});

    // Exhaustive sweep against the integer reference.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        accept(4'(a), 4'(b), 1'b0);
        wait_done(lat, bok);
        exp_v = ref_div(4'(a), 4'(b));
        check($sformatf("sweep_a%0d_b%0d", a, b), {lat[7:0], Q, R, div_zero, ovf},
              {8'd5, exp_v});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
